waveform_generator: RTL and testbench
=====================================

# waveform_generator

Sample source for the waveform-generator datapath, placed directly upstream of the amplitude selector. On each sample tick it advances an 8-bit phase accumulator and emits one unsigned 8-bit sample of the selected waveform: sawtooth up/down, triangle, square or sine. Waveform changes are deferred to the period boundary so the amplitude selector and DAC never see a mid-period discontinuity.

## Interface
- No parameters; sample width is fixed at 8 bits and the period is fixed at 256 samples.
- `clk` in 1: single clock. All logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: sample tick from the frequency divider, one cycle wide.
- `restart` in 1: synchronous restart of the period.
- `wave_sel` in 3: requested waveform.
- `data_out` out 8: current sample, registered. Feeds the amplitude selector's `data_in`.
- `valid` out 1: one-cycle pulse when `data_out` updates.

## Operation
- Registers:
  - `phase[7:0]`
  - `active_sel[2:0]`
  - `state` ∈ {IDLE, RUN, SWITCH}
  - `data_out`
  - `valid`
- Reset values: `phase=0`, `active_sel=0`, `state=IDLE`, `data_out=8'h80`, `valid=0`.
- Sample function f(sel,p):
  - 0 sawtooth up: p.
  - 1 sawtooth down: 255−p.
  - 2 triangle: p<128 ? 2p : 2(255−p). Values are p=0→0, 127→254, 128→254, 255→0.
  - 3 square: p<128 ? 8'hFF : 8'h00.
  - 4 sine: 128±q from a 65-entry quarter table, q[i]=round(127·sin(2πi/256)) for i=0..64.
    - p≤64: 128+q[p]
    - 65..127: 128+q[128−p]
    - 128..192: 128−q[p−128]
    - 193..255: 128−q[256−p]
    - Values are p=0→128, 64→255, 192→1.
  - 5 inverted sine: 255 − f(4,p).
  - 6, 7: constant 8'h80.
- FSM transitions, on a cycle with `en`=1 and `restart`=0:
  - IDLE: `active_sel`←`wave_sel`, emit f(`wave_sel`,0), `phase`←1, go to RUN.
  - RUN: emit f(`active_sel`,`phase`), `phase`←`phase`+1 (wraps 255→0). Go to SWITCH if `wave_sel`≠`active_sel`.
  - SWITCH: emit with the old `active_sel`.
    - If `phase`==255: `active_sel`←`wave_sel` and go to RUN, so the next sample (p=0) uses the new waveform.
    - If `wave_sel`==`active_sel` before the wrap: return to RUN.
- The `wave_sel` comparison is also made on cycles without `en`, so RUN↔SWITCH can change on any cycle. `active_sel` changes only as described above.
- `restart`=1: `phase`←0 and `state`←IDLE; `data_out` holds, `valid`=0. `restart` takes priority over a simultaneous `en`, and no sample is emitted that cycle.
- `en`=0 and `restart`=0: all registers hold except `valid`, which goes to 0 (and the RUN/SWITCH check above).
- Arithmetic is unsigned 8-bit. The triangle product uses `phase[6:0]`<<1, so it cannot overflow. Sine table entries are 7-bit.

## Timing
- Latency is 1 cycle: `data_out` and `valid` update on the same edge that samples `en`=1.
- `valid` is high for exactly one cycle per accepted `en`. Back-to-back `en` gives back-to-back samples.
- A `wave_sel` change takes effect at the first sample with p=0 after the change is seen, at most 256 `en` ticks later. Exception: from IDLE it takes effect on the next tick.
- Asserting `rst_n` low mid-period immediately forces the reset values, with no dependence on `clk`.

## Configuration
- `WAVEGEN_SINE_EN` defined: the quarter-sine table is instantiated and codes 4 and 5 behave as above.
- `WAVEGEN_SINE_EN` undefined: no table logic is built, and codes 4 and 5 output 8'h80 exactly like codes 6 and 7. The FSM and switching behaviour are unchanged.

## Structure
- Shared package `wavegen_pkg` holds:
  - the waveform-code constants WAVE_SAW_UP..WAVE_MID
  - the state enum
  - the midscale constant 8'h80
  - the period constant 256
- Sub-module `sine_quarter_rom`: combinational, 7-bit index in (0..64), 7-bit q out. It is instantiated only under `WAVEGEN_SINE_EN`.

## Test plan
- Reset with `wave_sel`=0, then 256 consecutive `en` ticks → `data_out`=0,1,…,255 with 256 `valid` pulses. The 257th tick gives 0.
- `wave_sel`=2, full period → samples at p=0, 64, 127, 128, 255 read 0, 128, 254, 254, 0.
- `wave_sel`=4 with `WAVEGEN_SINE_EN` → p=0, 64, 128, 192 give 128, 255, 128, 1. Without the macro, every sample is 8'h80.
- Running saw up, `wave_sel`→3 at p=10 → samples 10..255 remain sawtooth. The next sample (p=0) is 8'hFF and p=128 gives 8'h00.
- `restart` and `en` asserted together at p=100 → no `valid`, `data_out` holds 100. The next `en` emits f(`wave_sel`,0).
- `rst_n` pulled low between ticks mid-period → `data_out`=8'h80 and `valid`=0 immediately. The FSM returns to IDLE.

Source files
------------

// File: rtl/wavegen_pkg.sv
// Shared constants and state type for the waveform generator.
package wavegen_pkg;

  localparam logic [2:0] WAVE_SAW_UP   = 3'd0;
  localparam logic [2:0] WAVE_SAW_DN   = 3'd1;
  localparam logic [2:0] WAVE_TRI      = 3'd2;
  localparam logic [2:0] WAVE_SQUARE   = 3'd3;
  localparam logic [2:0] WAVE_SINE     = 3'd4;
  localparam logic [2:0] WAVE_SINE_INV = 3'd5;
  localparam logic [2:0] WAVE_MID      = 3'd6;

  localparam logic [7:0] MIDSCALE = 8'h80;
  localparam int         PERIOD   = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2
  } state_t;

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table: q[i] = round(127*sin(2*pi*i/256)), i = 0..64.
module sine_quarter_rom (
  input  logic [6:0] i_idx,
  output logic [6:0] o_q
);

  always_comb begin
    o_q = 7'd0;
    case (i_idx)
      7'd0:  o_q = 7'd0;    7'd1:  o_q = 7'd3;    7'd2:  o_q = 7'd6;
      7'd3:  o_q = 7'd9;    7'd4:  o_q = 7'd12;   7'd5:  o_q = 7'd16;
      7'd6:  o_q = 7'd19;   7'd7:  o_q = 7'd22;   7'd8:  o_q = 7'd25;
      7'd9:  o_q = 7'd28;   7'd10: o_q = 7'd31;   7'd11: o_q = 7'd34;
      7'd12: o_q = 7'd37;   7'd13: o_q = 7'd40;   7'd14: o_q = 7'd43;
      7'd15: o_q = 7'd46;   7'd16: o_q = 7'd49;   7'd17: o_q = 7'd51;
      7'd18: o_q = 7'd54;   7'd19: o_q = 7'd57;   7'd20: o_q = 7'd60;
      7'd21: o_q = 7'd63;   7'd22: o_q = 7'd65;   7'd23: o_q = 7'd68;
      7'd24: o_q = 7'd71;   7'd25: o_q = 7'd73;   7'd26: o_q = 7'd76;
      7'd27: o_q = 7'd78;   7'd28: o_q = 7'd81;   7'd29: o_q = 7'd83;
      7'd30: o_q = 7'd85;   7'd31: o_q = 7'd88;   7'd32: o_q = 7'd90;
      7'd33: o_q = 7'd92;   7'd34: o_q = 7'd94;   7'd35: o_q = 7'd96;
      7'd36: o_q = 7'd98;   7'd37: o_q = 7'd100;  7'd38: o_q = 7'd102;
      7'd39: o_q = 7'd104;  7'd40: o_q = 7'd106;  7'd41: o_q = 7'd107;
      7'd42: o_q = 7'd109;  7'd43: o_q = 7'd111;  7'd44: o_q = 7'd112;
      7'd45: o_q = 7'd113;  7'd46: o_q = 7'd115;  7'd47: o_q = 7'd116;
      7'd48: o_q = 7'd117;  7'd49: o_q = 7'd118;  7'd50: o_q = 7'd120;
      7'd51: o_q = 7'd121;  7'd52: o_q = 7'd122;  7'd53: o_q = 7'd122;
      7'd54: o_q = 7'd123;  7'd55: o_q = 7'd124;  7'd56: o_q = 7'd125;
      7'd57: o_q = 7'd125;  7'd58: o_q = 7'd126;  7'd59: o_q = 7'd126;
      7'd60: o_q = 7'd126;  7'd61: o_q = 7'd127;  7'd62: o_q = 7'd127;
      7'd63: o_q = 7'd127;  7'd64: o_q = 7'd127;
      default: o_q = 7'd0;
    endcase
  end

endmodule

// File: rtl/waveform_generator.sv
// 8-bit phase-accumulator waveform source; waveform changes commit at the period wrap.
// Optional feature macro: WAVEGEN_SINE_EN builds the sine table (codes 4/5), else they output midscale.
module waveform_generator
  import wavegen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       restart,
  input  logic [2:0] wave_sel,
  output logic [7:0] data_out,
  output logic       valid
);

  state_t     r_state, w_nstate;
  logic [7:0] r_phase, w_nphase;
  logic [2:0] r_active, w_nactive;
  logic [7:0] r_data, w_ndata;
  logic       r_valid, w_nvalid;

  logic [2:0] w_sel;
  logic [7:0] w_p;
  logic [7:0] w_sample;

  // From IDLE the first sample uses the requested waveform at phase 0.
  assign w_sel = (r_state == IDLE) ? wave_sel : r_active;
  assign w_p   = (r_state == IDLE) ? 8'd0 : r_phase;

`ifdef WAVEGEN_SINE_EN
  logic [6:0] w_half, w_sidx, w_q;
  logic [7:0] w_sine;

  assign w_half = w_p[6:0];
  // Second quarter mirrors the first: 128-h folds to -h in 7 bits.
  assign w_sidx = (w_half > 7'd64) ? (7'd0 - w_half) : w_half;
  assign w_sine = w_p[7] ? (MIDSCALE - {1'b0, w_q}) : (MIDSCALE + {1'b0, w_q});

  sine_quarter_rom u_rom (
    .i_idx (w_sidx),
    .o_q   (w_q)
  );
`endif

  always_comb begin
    w_sample = MIDSCALE;
    case (w_sel)
      WAVE_SAW_UP: w_sample = w_p;
      WAVE_SAW_DN: w_sample = ~w_p;
      WAVE_TRI:    w_sample = w_p[7] ? {~w_p[6:0], 1'b0} : {w_p[6:0], 1'b0};
      WAVE_SQUARE: w_sample = w_p[7] ? 8'h00 : 8'hFF;
`ifdef WAVEGEN_SINE_EN
      WAVE_SINE:     w_sample = w_sine;
      WAVE_SINE_INV: w_sample = ~w_sine;
`endif
      default:     w_sample = MIDSCALE;
    endcase
  end

  always_comb begin
    w_nstate  = r_state;
    w_nphase  = r_phase;
    w_nactive = r_active;
    w_ndata   = r_data;
    w_nvalid  = 1'b0;
    if (restart) begin
      w_nphase = 8'd0;
      w_nstate = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (en) begin
            w_nactive = wave_sel;
            w_ndata   = w_sample;
            w_nvalid  = 1'b1;
            w_nphase  = 8'd1;
            w_nstate  = RUN;
          end
        end
        RUN: begin
          if (en) begin
            w_ndata  = w_sample;
            w_nvalid = 1'b1;
            w_nphase = r_phase + 8'd1;
          end
          if (wave_sel != r_active) w_nstate = SWITCH;
        end
        SWITCH: begin
          if (en) begin
            w_ndata  = w_sample;
            w_nvalid = 1'b1;
            w_nphase = r_phase + 8'd1;
          end
          // Commit on the last sample of the period so p=0 uses the new waveform.
          if (en && r_phase == 8'hFF) begin
            w_nactive = wave_sel;
            w_nstate  = RUN;
          end else if (wave_sel == r_active) begin
            w_nstate = RUN;
          end
        end
        default: w_nstate = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_phase  <= 8'd0;
      r_active <= 3'd0;
      r_data   <= MIDSCALE;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_phase  <= w_nphase;
      r_active <= w_nactive;
      r_data   <= w_ndata;
      r_valid  <= w_nvalid;
    end
  end

  assign data_out = r_data;
  assign valid    = r_valid;

endmodule

// File: tb/tb_waveform_generator.sv
// Self-checking bench for waveform_generator: vector table, directed corner sequences, random run vs model.
module tb_waveform_generator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       restart;
  logic [2:0] wave_sel;
  logic [7:0] data_out;
  logic       valid;

  int checks = 0;
  int errors = 0;

  // Reference model state: idle flag, phase, committed waveform, pending-change flag.
  bit       m_idle;
  int       m_phase;
  int       m_active;
  bit       m_pend;
  int       m_data;
  int       m_valid;

  typedef struct {
    logic       en;
    logic       rs;
    logic [2:0] sel;
    logic [7:0] d;
    logic       v;
  } vec_t;

  vec_t tbl[9];

  waveform_generator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .restart  (restart),
    .wave_sel (wave_sel),
    .data_out (data_out),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  function automatic int qsine(int p);
    real s;
    s = 127.0 * $sin(2.0 * 3.14159265358979 * p / 256.0);
    return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
  endfunction

  function automatic int fref(int sel, int p);
    case (sel)
      0: return p;
      1: return 255 - p;
      2: return (p < 128) ? 2 * p : 2 * (255 - p);
      3: return (p < 128) ? 255 : 0;
`ifdef WAVEGEN_SINE_EN
      4: return 128 + qsine(p);
      5: return 255 - (128 + qsine(p));
`endif
      default: return 128;
    endcase
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_idle = 1; m_phase = 0; m_active = 0; m_pend = 0; m_data = 128; m_valid = 0;
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic tick(input logic e, input logic r, input logic [2:0] s);
    bit commit;
    en = e; restart = r; wave_sel = s;
    if (r) begin
      m_phase = 0; m_idle = 1; m_valid = 0; m_pend = 0;
    end else if (m_idle) begin
      m_valid = e ? 1 : 0;
      if (e) begin
        m_active = s; m_data = fref(s, 0); m_phase = 1; m_idle = 0;
      end
    end else begin
      commit  = e && m_pend && (m_phase == 255);
      m_valid = e ? 1 : 0;
      if (e) begin
        m_data  = fref(m_active, m_phase);
        m_phase = (m_phase + 1) % 256;
      end
      m_pend = !commit && (int'(s) != m_active);
      if (commit) m_active = s;
    end
    @(posedge clk);
    #1;
    check("data_model", data_out, m_data);
    check("valid_model", valid, m_valid);
  endtask

  initial begin
    int exp;
    rst_n = 1'b0; en = 1'b0; restart = 1'b0; wave_sel = 3'd0;
    model_reset();
    #12;
    check("reset_data", data_out, 8'h80);
    check("reset_valid", valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table: IDLE start, hold, switch request/cancel, restart.
    tbl[0] = '{1'b1, 1'b0, 3'd2, 8'd0,   1'b1};
    tbl[1] = '{1'b0, 1'b0, 3'd2, 8'd0,   1'b0};
    tbl[2] = '{1'b1, 1'b0, 3'd2, 8'd2,   1'b1};
    tbl[3] = '{1'b1, 1'b0, 3'd1, 8'd4,   1'b1};
    tbl[4] = '{1'b1, 1'b1, 3'd1, 8'd4,   1'b0};
    tbl[5] = '{1'b1, 1'b0, 3'd1, 8'd255, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 3'd1, 8'd254, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 3'd6, 8'd253, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 3'd1, 8'd252, 1'b1};
    for (int i = 0; i < 9; i++) begin
      tick(tbl[i].en, tbl[i].rs, tbl[i].sel);
      check($sformatf("vec%0d_data", i), data_out, tbl[i].d);
      check($sformatf("vec%0d_valid", i), valid, tbl[i].v);
    end

    // Sawtooth up: full period then wrap.
    tick(1'b0, 1'b1, 3'd0);
    for (int i = 0; i < 257; i++) begin
      tick(1'b1, 1'b0, 3'd0);
      check("saw_sample", data_out, i % 256);
      check("saw_valid", valid, 1);
    end

    // Triangle landmarks.
    tick(1'b0, 1'b1, 3'd2);
    for (int i = 0; i < 256; i++) begin
      tick(1'b1, 1'b0, 3'd2);
      case (i)
        0:   check("tri_p0", data_out, 0);
        64:  check("tri_p64", data_out, 128);
        127: check("tri_p127", data_out, 254);
        128: check("tri_p128", data_out, 254);
        255: check("tri_p255", data_out, 0);
        default: ;
      endcase
    end

    // Sine landmarks (midscale throughout without the table).
    tick(1'b0, 1'b1, 3'd4);
    for (int i = 0; i < 256; i++) begin
      tick(1'b1, 1'b0, 3'd4);
`ifdef WAVEGEN_SINE_EN
      case (i)
        0:   check("sine_p0", data_out, 128);
        64:  check("sine_p64", data_out, 255);
        128: check("sine_p128", data_out, 128);
        192: check("sine_p192", data_out, 1);
        default: ;
      endcase
`else
      check("sine_off", data_out, 128);
`endif
    end

    // Saw up, request square after p=10: change lands at p=0.
    tick(1'b0, 1'b1, 3'd0);
    for (int i = 0; i <= 10; i++) tick(1'b1, 1'b0, 3'd0);
    check("sw_p10", data_out, 10);
    tick(1'b0, 1'b0, 3'd3);
    for (int i = 11; i < 256; i++) begin
      tick(1'b1, 1'b0, 3'd3);
      check("sw_old_saw", data_out, i);
    end
    tick(1'b1, 1'b0, 3'd3);
    check("sw_new_p0", data_out, 8'hFF);
    for (int i = 1; i <= 128; i++) tick(1'b1, 1'b0, 3'd3);
    check("sw_new_p128", data_out, 8'h00);

    // restart together with en at p=100.
    tick(1'b0, 1'b1, 3'd0);
    for (int i = 0; i <= 100; i++) tick(1'b1, 1'b0, 3'd0);
    tick(1'b1, 1'b1, 3'd1);
    check("rst_en_valid", valid, 0);
    check("rst_en_hold", data_out, 100);
    tick(1'b1, 1'b0, 3'd1);
    check("rst_en_next", data_out, 255);
    check("rst_en_next_v", valid, 1);

    // Async reset between ticks.
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 3'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_data", data_out, 8'h80);
    check("async_valid", valid, 0);
    model_reset();
    en = 1'b0; restart = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tick(1'b1, 1'b0, 3'd3);
    check("post_reset_idle", data_out, 8'hFF);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic e, r;
      logic [2:0] s;
      e = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 199) == 0);
      s = wave_sel;
      if ($urandom_range(0, 299) == 0) s = 3'($urandom_range(0, 7));
      tick(e, r, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
